// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin sharing of one fixed-latency memory port between
// instruction fetch and data access, with registered per-owner read-data return.
module memory_port_arbiter #(
  parameter int         READ_LATENCY = 1,
  parameter logic [2:0] FETCH_FUNCT3 = 3'b010
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] memory_read_address,
  output logic [31:0] memory_write_address,
  output logic [31:0] memory_write,
  output logic        memory_write_en,
  output logic [2:0]  memory_funct3,
  input  logic [31:0] memory_read_value
);
  typedef enum logic {IDLE, READ_WAIT} state_t;
  state_t      state, state_next;
  logic        last_d, owner_d;
  logic [2:0]  cnt;
  logic [31:0] lat_addr;
  logic [2:0]  lat_f3;
  logic        idle, grant_if, grant_d, read_start, done;
  // Grants are gated by reset_n so nothing reaches the memory while reset is held.
  always_comb begin
    idle = reset_n && state == IDLE;
    grant_if = idle && if_req && (!d_req || last_d);
    grant_d = idle && d_req && (!if_req || !last_d);
    read_start = grant_if || (grant_d && !d_we);
    done = state == READ_WAIT && cnt == 3'd1;
    state_next = state == IDLE ? (read_start ? READ_WAIT : IDLE) : (done ? IDLE : READ_WAIT);
  end
  assign if_gnt = grant_if;
  assign d_gnt = grant_d;
  assign memory_write_en = grant_d && d_we;
  assign memory_write_address = memory_write_en ? d_addr : '0;
  assign memory_write = memory_write_en ? d_wdata : '0;
  assign memory_read_address = state == READ_WAIT ? lat_addr : grant_if ? if_addr : read_start ? d_addr : '0;
  assign memory_funct3 = state == READ_WAIT ? lat_f3 : grant_d ? d_funct3 : FETCH_FUNCT3;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end
  // The counter reaches 1 in cycle T+READ_LATENCY, when the memory data is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d <= 1'b1;
      owner_d <= 1'b0;
      cnt <= '0;
      lat_addr <= '0;
      lat_f3 <= FETCH_FUNCT3;
      if_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if_rvalid <= done && !owner_d;
      d_rvalid <= done && owner_d;
      if (grant_if || grant_d) last_d <= grant_d;
      if (read_start) begin
        lat_addr <= memory_read_address;
        lat_f3 <= memory_funct3;
        owner_d <= grant_d;
        cnt <= 3'(READ_LATENCY);
      end else if (state == READ_WAIT) cnt <= cnt - 3'd1;
      if (done && !owner_d) if_rdata <= memory_read_value;
      if (done && owner_d) d_rdata <= memory_read_value;
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed and random stimulus against a cycle-level model of
// arbitration, read occupancy and data return.
module tb_memory_port_arbiter;
  localparam int         LAT = 3;
  localparam logic [2:0] FF3 = 3'b010;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0]  d_funct3 = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, memory_write_en;
  logic [31:0] if_rdata, d_rdata, memory_read_address, memory_write_address, memory_write, memory_read_value;
  logic [2:0]  memory_funct3;
  logic [31:0] mem [256];
  logic [31:0] pipe [LAT];
  int          checks = 0, fails = 0, cyc = 0, busy_until = -1, n_d;
  bit          m_last_d, m_owner_d, e_if_rv, e_d_rv, seen_if_gnt, seen_d_gnt;
  logic [31:0] m_raddr, e_if_rd, e_d_rd;
  logic [2:0]  m_rf3;
  bit          order [$];
  always #5 clk = ~clk;
  memory_port_arbiter #(.READ_LATENCY(LAT), .FETCH_FUNCT3(FF3)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .memory_read_address(memory_read_address), .memory_write_address(memory_write_address),
    .memory_write(memory_write), .memory_write_en(memory_write_en), .memory_funct3(memory_funct3),
    .memory_read_value(memory_read_value)
  );
  // Memory with LAT-cycle read latency; contents are re-seeded while reset is held.
  assign memory_read_value = mem[pipe[LAT-1][9:2]];
  always @(posedge clk) begin
    pipe[0] <= memory_read_address;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i * 32'h9E3779B1) ^ 32'h5A5A0000;
      mem[64] <= 32'h00500093;
    end else if (memory_write_en) mem[memory_write_address[9:2]] <= memory_write;
  end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_last_d = 1'b1;
    busy_until = -1;
    e_if_rv = 1'b0;
    e_d_rv = 1'b0;
    e_if_rd = '0;
    e_d_rd = '0;
    cyc = 0;
  endtask
  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic step();
    bit busy, g_if, g_d, rd_d, we;
    @(negedge clk);
    busy = cyc <= busy_until;
    g_if = !busy && if_req && (!d_req || m_last_d);
    g_d = !busy && d_req && !g_if;
    rd_d = g_d && !d_we;
    we = g_d && d_we;
    chk("if_gnt", 32'(if_gnt), 32'(g_if));
    chk("d_gnt", 32'(d_gnt), 32'(g_d));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
    chk("d_rvalid", 32'(d_rvalid), 32'(e_d_rv));
    chk("if_rdata", if_rdata, e_if_rd);
    chk("d_rdata", d_rdata, e_d_rd);
    chk("rd_addr", memory_read_address, busy ? m_raddr : g_if ? if_addr : rd_d ? d_addr : 32'd0);
    chk("wr_addr", memory_write_address, we ? d_addr : 32'd0);
    chk("wr_data", memory_write, we ? d_wdata : 32'd0);
    chk("wr_en", 32'(memory_write_en), 32'(we));
    chk("funct3", 32'(memory_funct3), 32'(busy ? m_rf3 : g_d ? d_funct3 : FF3));
    seen_if_gnt = if_gnt;
    seen_d_gnt = d_gnt;
    if (if_gnt || d_gnt) order.push_back(d_gnt);
    @(posedge clk);
    e_if_rv = 1'b0;
    e_d_rv = 1'b0;
    if (busy && cyc == busy_until) begin
      if (m_owner_d) begin e_d_rd = mem[m_raddr[9:2]]; e_d_rv = 1'b1; end
      else begin e_if_rd = mem[m_raddr[9:2]]; e_if_rv = 1'b1; end
    end
    if (g_if || g_d) m_last_d = g_d;
    if (g_if || rd_d) begin
      busy_until = cyc + LAT;
      m_raddr = g_if ? if_addr : d_addr;
      m_rf3 = g_if ? FF3 : d_funct3;
      m_owner_d = rd_d;
    end
    cyc++;
    #1;
  endtask
  task automatic drive_random();
    if (!if_req || seen_if_gnt) begin
      if_req = $urandom_range(0, 2) != 0;
      if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    end else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
    if (!d_req || seen_d_gnt) begin
      d_req = $urandom_range(0, 2) != 0;
      d_we = 1'($urandom_range(0, 1));
      d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d_wdata = $urandom();
      d_funct3 = 3'($urandom_range(0, 7));
    end else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
  endtask
  task automatic check_reset_outputs(string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
    chk({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_rd_addr"}, memory_read_address, 32'd0);
    chk({tag, "_wr_addr"}, memory_write_address, 32'd0);
    chk({tag, "_wr_data"}, memory_write, 32'd0);
    chk({tag, "_wr_en"}, 32'(memory_write_en), 32'd0);
    chk({tag, "_funct3"}, 32'(memory_funct3), 32'(FF3));
  endtask
  initial begin
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(posedge clk);
    #3 reset_n = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h100;
    step();
    chk("t1_first_gnt_if", 32'(seen_if_gnt), 32'd1);
    if_req = 1'b0;
    repeat (LAT + 1) step();
    chk("t1_if_rdata", if_rdata, 32'h00500093);
    order.delete();
    if_req = 1'b1;
    if_addr = 32'h0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h40;
    d_funct3 = 3'b010;
    repeat (3 * (LAT + 1)) step();
    chk("t2_grants", 32'(order.size()), 32'd3);
    if (order.size() == 3) begin
      chk("t2_alt01", 32'(order[1] != order[0]), 32'd1);
      chk("t2_alt12", 32'(order[2] != order[1]), 32'd1);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (LAT + 1) step();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h80;
    d_wdata = 32'hDEADBEEF;
    d_funct3 = 3'b010;
    step();
    d_req = 1'b0;
    step();
    chk("t3_mem", mem[32], 32'hDEADBEEF);
    n_d = 0;
    for (int k = 0; k < 4; k++) begin
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 32'h200 + 32'(4 * k);
      d_wdata = $urandom();
      d_funct3 = 3'($urandom_range(0, 7));
      step();
      n_d += int'(seen_d_gnt);
    end
    d_req = 1'b0;
    chk("t6_store_gnts", 32'(n_d), 32'd4);
    if_req = 1'b1;
    if_addr = 32'h104;
    step();
    if_req = 1'b0;
    step();
    #2 if_req = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    chk("t5_regrant", 32'(seen_if_gnt), 32'd1);
    if_req = 1'b0;
    repeat (LAT + 2) step();
    repeat (800) begin
      step();
      drive_random();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
